// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the dual-player Tetris design.
//   COLS / ROWS     : playfield geometry (row 0 is the top row)
//   color_e         : cell colour codes, 0 = empty, 1..7 = tetromino colours
//   state_t, ST_*   : board_store sequencer states
//   cell_addr()     : linear cell address row*cols+col, as used by the display
// -----------------------------------------------------------------------------
package tetris_pkg;

   localparam int COLS = 10;
   localparam int ROWS = 20;

   typedef enum logic [2:0] {
      CELL_EMPTY = 3'd0,
      PIECE_I    = 3'd1,
      PIECE_J    = 3'd2,
      PIECE_L    = 3'd3,
      PIECE_O    = 3'd4,
      PIECE_S    = 3'd5,
      PIECE_T    = 3'd6,
      PIECE_Z    = 3'd7
   } color_e;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SCAN  = 2'd1;
   localparam state_t ST_SHIFT = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   function automatic logic [7:0] cell_addr(input int row, input int col, input int cols);
      return 8'(row * cols + col);
   endfunction

endpackage

// File: rtl/board_query.sv
// -----------------------------------------------------------------------------
// board_query
// Combinational collision check of four query cells against the playfield.
//   occ            in  ROWS*COLS  occupancy bit per cell, index row*COLS+col
//   qx1..qy4       in  5 each     query cells (column, row)
//   qhit           out 1          any query cell is out of bounds or occupied
// -----------------------------------------------------------------------------
module board_query #(
   parameter int COLS = tetris_pkg::COLS,
   parameter int ROWS = tetris_pkg::ROWS
) (
   input  logic [ROWS*COLS-1:0] occ,
   input  logic [4:0]           qx1,
   input  logic [4:0]           qy1,
   input  logic [4:0]           qx2,
   input  logic [4:0]           qy2,
   input  logic [4:0]           qx3,
   input  logic [4:0]           qy3,
   input  logic [4:0]           qx4,
   input  logic [4:0]           qy4,
   output logic                 qhit
);
   import tetris_pkg::*;

   logic [4:0] qx [4];
   logic [4:0] qy [4];
   logic [3:0] hit;

   assign qx[0] = qx1;  assign qy[0] = qy1;
   assign qx[1] = qx2;  assign qy[1] = qy2;
   assign qx[2] = qx3;  assign qy[2] = qy3;
   assign qx[3] = qx4;  assign qy[3] = qy4;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_q
         // Out-of-bounds cells count as walls; the occupancy lookup is only
         // selected when the coordinate lies inside the board.
         assign hit[gi] = (int'(qx[gi]) >= COLS || int'(qy[gi]) >= ROWS) ? 1'b1 :
                          occ[cell_addr(int'(qy[gi]), int'(qx[gi]), COLS)];
      end
   endgenerate

   assign qhit = |hit;

endmodule

// File: rtl/board_store.sv
// -----------------------------------------------------------------------------
// board_store
// Per-player playfield memory. Locks pieces in, clears full rows bottom-up
// and collapses the rows above, reports lines cleared and top-out.
//   pclk, rstn          clock, asynchronous active-low reset
//   clr                 synchronous new-game clear (highest priority)
//   lock_req            lock the piece given by x1..y4 with colour color
//   raddr / rdata       combinational display read, 0 for empty or raddr>=ROWS*COLS
//   qx1..qy4 / qhit     combinational collision query
//   busy                lock/clear sequence in progress
//   done                one-cycle pulse at end of sequence
//   lines               rows cleared by the last sequence (saturates at 7)
//   fail                sticky top-out flag
// -----------------------------------------------------------------------------
module board_store #(
   parameter int COLS        = tetris_pkg::COLS,
   parameter int ROWS        = tetris_pkg::ROWS,
   parameter int DANGER_ROWS = 3
) (
   input  logic       pclk,
   input  logic       rstn,
   input  logic       clr,
   input  logic       lock_req,
   input  logic [4:0] x1,
   input  logic [4:0] y1,
   input  logic [4:0] x2,
   input  logic [4:0] y2,
   input  logic [4:0] x3,
   input  logic [4:0] y3,
   input  logic [4:0] x4,
   input  logic [4:0] y4,
   input  logic [2:0] color,
   input  logic [7:0] raddr,
   output logic [2:0] rdata,
   input  logic [4:0] qx1,
   input  logic [4:0] qy1,
   input  logic [4:0] qx2,
   input  logic [4:0] qy2,
   input  logic [4:0] qx3,
   input  logic [4:0] qy3,
   input  logic [4:0] qx4,
   input  logic [4:0] qy4,
   output logic       qhit,
   output logic       busy,
   output logic       done,
   output logic [2:0] lines,
   output logic       fail
);
   import tetris_pkg::*;

   // Flop storage: whole-row moves and a same-cycle display read rule out RAM.
   logic [2:0]           cells [ROWS][COLS];
   logic [2:0]           flat  [ROWS*COLS];
   logic [ROWS*COLS-1:0] occ;
   logic [ROWS-1:0]      row_full;
   logic [ROWS-1:0]      row_any;

   state_t     state_reg;
   logic [4:0] r_reg;       // row under scan
   logic [4:0] k_reg;       // row being refilled from the row above
   logic       busy_reg;
   logic [2:0] lines_reg;
   logic       fail_reg;

   logic [4:0] px [4];
   logic [4:0] py [4];

   assign px[0] = x1;  assign py[0] = y1;
   assign px[1] = x2;  assign py[1] = y2;
   assign px[2] = x3;  assign py[2] = y3;
   assign px[3] = x4;  assign py[3] = y4;

   genvar gi, gj;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row
         logic [COLS-1:0] nz;
         for (gj = 0; gj < COLS; gj++) begin : g_col
            assign nz[gj]               = |cells[gi][gj];
            assign flat[gi*COLS + gj]   = cells[gi][gj];
            assign occ[gi*COLS + gj]    = nz[gj];
         end
         assign row_full[gi] = &nz;
         assign row_any[gi]  = |nz;
      end
   endgenerate

   always_comb begin
      rdata = 3'd0;
      if (int'(raddr) < ROWS*COLS)
         rdata = flat[raddr];
   end

   board_query #(.COLS(COLS), .ROWS(ROWS)) u_query (
      .occ  (occ),
      .qx1  (qx1), .qy1 (qy1),
      .qx2  (qx2), .qy2 (qy2),
      .qx3  (qx3), .qy3 (qy3),
      .qx4  (qx4), .qy4 (qy4),
      .qhit (qhit)
   );

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         for (int rr = 0; rr < ROWS; rr++)
            for (int c = 0; c < COLS; c++)
               cells[rr][c] <= 3'd0;
         state_reg <= ST_IDLE;
         r_reg     <= 5'd0;
         k_reg     <= 5'd0;
         busy_reg  <= 1'b0;
         lines_reg <= 3'd0;
         fail_reg  <= 1'b0;
      end else if (clr) begin
         for (int rr = 0; rr < ROWS; rr++)
            for (int c = 0; c < COLS; c++)
               cells[rr][c] <= 3'd0;
         state_reg <= ST_IDLE;
         r_reg     <= 5'd0;
         k_reg     <= 5'd0;
         busy_reg  <= 1'b0;
         lines_reg <= 3'd0;
         fail_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (lock_req) begin
                  // Out-of-range coordinates never match a row/column and are
                  // therefore dropped; duplicates just write the same colour.
                  for (int rr = 0; rr < ROWS; rr++)
                     for (int c = 0; c < COLS; c++)
                        for (int p = 0; p < 4; p++)
                           if (int'(py[p]) == rr && int'(px[p]) == c)
                              cells[rr][c] <= color;
                  lines_reg <= 3'd0;
                  busy_reg  <= 1'b1;
                  r_reg     <= 5'(ROWS - 1);
                  state_reg <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (row_full[r_reg]) begin
                  if (lines_reg != 3'd7)
                     lines_reg <= lines_reg + 3'd1;
                  k_reg     <= r_reg;
                  state_reg <= ST_SHIFT;
               end else if (r_reg == 5'd0) begin
                  state_reg <= ST_DONE;
               end else begin
                  r_reg <= r_reg - 5'd1;
               end
            end
            ST_SHIFT: begin
               for (int rr = 1; rr < ROWS; rr++)
                  if (int'(k_reg) == rr)
                     for (int c = 0; c < COLS; c++)
                        cells[rr][c] <= cells[rr-1][c];
               // The top row has nothing above it, so it is emptied on the
               // last shift step (k=1) or on its own when the target was row 0.
               if (k_reg <= 5'd1) begin
                  for (int c = 0; c < COLS; c++)
                     cells[0][c] <= 3'd0;
                  state_reg <= ST_SCAN;   // rescan same r: it holds new contents
               end else begin
                  k_reg <= k_reg - 5'd1;
               end
            end
            ST_DONE: begin
               busy_reg <= 1'b0;
               if (|row_any[DANGER_ROWS-1:0])
                  fail_reg <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign busy  = busy_reg;
   assign done  = (state_reg == ST_DONE);
   assign lines = lines_reg;
   assign fail  = fail_reg;

endmodule

// File: tb/tb_board_store.sv
`timescale 1ns/1ps
module tb_board_store;
   import tetris_pkg::*;

   localparam int NC = 10;
   localparam int NR = 20;
   localparam int ND = 3;

   logic       pclk = 1'b0;
   logic       rstn = 1'b0;
   logic       clr = 1'b0;
   logic       lock_req = 1'b0;
   logic [4:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, x3 = '0, y3 = '0, x4 = '0, y4 = '0;
   logic [2:0] color = '0;
   logic [7:0] raddr = '0;
   logic [2:0] rdata;
   logic [4:0] qx1 = '0, qy1 = '0, qx2 = '0, qy2 = '0, qx3 = '0, qy3 = '0, qx4 = '0, qy4 = '0;
   logic       qhit, busy, done, fail;
   logic [2:0] lines;

   board_store dut (
      .pclk(pclk), .rstn(rstn), .clr(clr), .lock_req(lock_req),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3), .x4(x4), .y4(y4),
      .color(color), .raddr(raddr), .rdata(rdata),
      .qx1(qx1), .qy1(qy1), .qx2(qx2), .qy2(qy2), .qx3(qx3), .qy3(qy3), .qx4(qx4), .qy4(qy4),
      .qhit(qhit), .busy(busy), .done(done), .lines(lines), .fail(fail)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   // Reference model state: board contents, sticky fail, last line count
   int brd [NR][NC];
   bit m_fail = 1'b0;
   int last_nl = 0;
   int cx [4];
   int cy [4];
   int qxa [4];
   int qya [4];
   int nlock = 0;

   typedef struct { int done_cyc; int nl; bit fl; } exp_t;
   exp_t sbq [$];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            brd[r][c] = 0;
      m_fail  = 1'b0;
      last_nl = 0;
   endtask

   // Lock the piece, then remove every full row and let the rest fall.
   // A full row first found at index f, with m full rows below it removed
   // first, is cleared while sitting at f+m; each clear costs max(that,1)+1.
   task automatic model_lock(input int c, output int nl, output int lat);
      bit full [NR];
      int nb [NR][NC];
      int m, t, dst;
      for (int p = 0; p < 4; p++)
         if (cx[p] < NC && cy[p] < NR) brd[cy[p]][cx[p]] = c;
      for (int r = 0; r < NR; r++) begin
         full[r] = 1'b1;
         for (int k = 0; k < NC; k++) if (brd[r][k] == 0) full[r] = 1'b0;
      end
      lat = NR + 1;
      m = 0;
      for (int r = NR - 1; r >= 0; r--)
         if (full[r]) begin
            t = r + m;
            lat += ((t > 1) ? t : 1) + 1;
            m++;
         end
      for (int r = 0; r < NR; r++)
         for (int k = 0; k < NC; k++) nb[r][k] = 0;
      dst = NR - 1;
      for (int r = NR - 1; r >= 0; r--)
         if (!full[r]) begin
            for (int k = 0; k < NC; k++) nb[dst][k] = brd[r][k];
            dst--;
         end
      for (int r = 0; r < NR; r++)
         for (int k = 0; k < NC; k++) brd[r][k] = nb[r][k];
      nl = (m > 7) ? 7 : m;
      for (int r = 0; r < ND; r++)
         for (int k = 0; k < NC; k++) if (brd[r][k] != 0) m_fail = 1'b1;
   endtask

   task automatic drive_cells(input int c);
      x1 = 5'(cx[0]); y1 = 5'(cy[0]);
      x2 = 5'(cx[1]); y2 = 5'(cy[1]);
      x3 = 5'(cx[2]); y3 = 5'(cy[2]);
      x4 = 5'(cx[3]); y4 = 5'(cy[3]);
      color = 3'(c);
   endtask

   task automatic set_piece(input int a0, b0, a1, b1, a2, b2, a3, b3);
      cx[0] = a0; cy[0] = b0; cx[1] = a1; cy[1] = b1;
      cx[2] = a2; cy[2] = b2; cx[3] = a3; cy[3] = b3;
   endtask

   task automatic start_lock(input int c);
      int nl, lat;
      exp_t e;
      @(negedge pclk);
      drive_cells(c);
      lock_req = 1'b1;
      @(posedge pclk);
      #1;
      lock_req = 1'b0;
      model_lock(c, nl, lat);
      e.done_cyc = cyc + lat - 1;
      e.nl = nl;
      e.fl = m_fail;
      sbq.push_back(e);
      last_nl = nl;
      nlock++;
      $display("lock %0d color=%0d cells=(%0d,%0d)(%0d,%0d)(%0d,%0d)(%0d,%0d) exp_lines=%0d exp_latency=%0d exp_fail=%0d",
               nlock, c, cx[0], cy[0], cx[1], cy[1], cx[2], cy[2], cx[3], cy[3], nl, lat, m_fail);
   endtask

   task automatic sweep(input string tag);
      int e;
      for (int a = 0; a < NR*NC; a++) begin
         raddr = 8'(a);
         #1;
         e = brd[a / NC][a % NC];
         if (int'(rdata) != e) chk($sformatf("%s rdata[%0d]", tag, a), int'(rdata), e);
         else checks++;
      end
   endtask

   task automatic finish_lock(input string tag);
      int n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (busy !== 1'b0 && n < 400);
      chk({tag, " busy_released"}, int'(busy), 0);
      chk({tag, " lines_held"}, int'(lines), last_nl);
      sweep(tag);
   endtask

   task automatic lock(input int c, input string tag);
      start_lock(c);
      finish_lock(tag);
   endtask

   task automatic do_clr();
      @(negedge pclk);
      clr = 1'b1;
      @(posedge pclk);
      #1;
      clr = 1'b0;
      model_clear();
      sbq.delete();
      chk("clr busy", int'(busy), 0);
      chk("clr done", int'(done), 0);
      chk("clr lines", int'(lines), 0);
      chk("clr fail", int'(fail), 0);
   endtask

   task automatic query_check(input string nm);
      int e = 0;
      qx1 = 5'(qxa[0]); qy1 = 5'(qya[0]);
      qx2 = 5'(qxa[1]); qy2 = 5'(qya[1]);
      qx3 = 5'(qxa[2]); qy3 = 5'(qya[2]);
      qx4 = 5'(qxa[3]); qy4 = 5'(qya[3]);
      #1;
      for (int p = 0; p < 4; p++)
         if (qxa[p] >= NC || qya[p] >= NR) e = 1;
         else if (brd[qya[p]][qxa[p]] != 0) e = 1;
      chk(nm, int'(qhit), e);
   endtask

   task automatic query1(input int x, input int y);
      for (int p = 0; p < 4; p++) begin qxa[p] = x; qya[p] = y; end
      query_check($sformatf("qhit(%0d,%0d)", x, y));
   endtask

   // Monitor: every done pulse must match the oldest outstanding lock.
   initial begin
      forever begin
         @(negedge pclk);
         if (rstn === 1'b1 && done === 1'b1) begin
            chk("done_expected", int'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
               exp_t e;
               e = sbq.pop_front();
               chk("done_cycle", cyc, e.done_cyc);
               chk("lines_at_done", int'(lines), e.nl);
               @(negedge pclk);
               chk("fail_after_done", int'(fail), int'(e.fl));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      model_clear();

      // Reset state
      repeat (3) @(negedge pclk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset lines", int'(lines), 0);
      chk("reset fail", int'(fail), 0);
      sweep("reset");
      raddr = 8'd250;
      #1;
      chk("rdata(250)", int'(rdata), 0);
      @(negedge pclk);
      rstn = 1'b1;

      // O piece at the bottom
      set_piece(4, 18, 5, 18, 4, 19, 5, 19);
      lock(int'(PIECE_O), "o_piece");

      // Single line clear at row 19
      do_clr();
      set_piece(0, 19, 1, 19, 2, 19, 3, 19);
      lock(int'(PIECE_J), "fill_a");
      set_piece(4, 19, 5, 19, 8, 19, 9, 19);
      lock(int'(PIECE_L), "fill_b");
      set_piece(6, 16, 6, 17, 6, 18, 6, 19);
      lock(int'(PIECE_I), "i_col6");
      set_piece(7, 16, 7, 17, 7, 18, 7, 19);
      lock(int'(PIECE_I), "i_col7");

      // Tetris: four lines at once
      do_clr();
      for (int r = 16; r < 20; r++) begin
         set_piece(0, r, 1, r, 2, r, 3, r);
         lock(int'(PIECE_S), "fill4");
         set_piece(4, r, 5, r, 6, r, 7, r);
         lock(int'(PIECE_Z), "fill4");
      end
      set_piece(8, 16, 8, 17, 8, 18, 8, 19);
      lock(int'(PIECE_J), "fill4");
      set_piece(9, 16, 9, 17, 9, 18, 9, 19);
      lock(int'(PIECE_I), "tetris");
      query1(9, 19);

      // Top-out is sticky until clr
      do_clr();
      set_piece(4, 0, 3, 1, 4, 1, 5, 1);
      lock(int'(PIECE_T), "t_top");
      chk("fail set", int'(fail), 1);
      set_piece(0, 19, 1, 19, 2, 19, 3, 19);
      lock(int'(PIECE_I), "after_fail");
      do_clr();
      sweep("after_clr");

      // Boundary queries
      query1(10, 0);
      query1(3, 5);
      query1(0, 20);

      // clr during SHIFT aborts without done
      set_piece(0, 19, 1, 19, 2, 19, 3, 19);
      lock(int'(PIECE_I), "pre_a");
      set_piece(4, 19, 5, 19, 6, 19, 7, 19);
      lock(int'(PIECE_I), "pre_b");
      set_piece(8, 19, 9, 19, 8, 18, 9, 18);
      start_lock(int'(PIECE_O));
      repeat (10) @(negedge pclk);
      chk("busy mid_shift", int'(busy), 1);
      do_clr();
      cnt = 0;
      repeat (60) begin
         @(negedge pclk);
         if (done === 1'b1) cnt++;
      end
      chk("no_done_after_clr", cnt, 0);
      sweep("abort");

      // lock_req while busy is ignored
      set_piece(0, 19, 1, 19, 0, 18, 1, 18);
      start_lock(int'(PIECE_O));
      repeat (5) @(negedge pclk);
      set_piece(5, 10, 6, 10, 5, 11, 6, 11);
      drive_cells(int'(PIECE_Z));
      lock_req = 1'b1;
      @(posedge pclk);
      #1;
      lock_req = 1'b0;
      finish_lock("ignored_lock");

      // Asynchronous reset mid-sequence
      set_piece(3, 19, 4, 19, 3, 18, 4, 18);
      start_lock(int'(PIECE_O));
      repeat (8) @(negedge pclk);
      rstn = 1'b0;
      #1;
      chk("async_rst busy", int'(busy), 0);
      chk("async_rst lines", int'(lines), 0);
      chk("async_rst done", int'(done), 0);
      model_clear();
      sbq.delete();
      sweep("async_rst");
      rstn = 1'b1;

      // Randomised locks and queries
      do_clr();
      for (int n = 0; n < 40; n++) begin
         for (int p = 0; p < 4; p++) begin
            cx[p] = $urandom_range(0, 10);
            cy[p] = $urandom_range(13, 20);
         end
         lock($urandom_range(1, 7), "rand");
         for (int p = 0; p < 4; p++) begin
            qxa[p] = $urandom_range(0, 10);
            qya[p] = $urandom_range(10, 20);
         end
         query_check("qhit_rand");
      end

      repeat (5) @(negedge pclk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
